pc_seq: RTL and testbench
=========================

# pc_seq

Instruction-fetch sequencer for the MIPS32 datapath. It owns the architectural PC register as a 30-bit word address [31:2] and issues one instruction-memory request at a time over a req/ack handshake. It presents fetched instructions to decode over a valid/ready handshake. It applies control-flow redirects (the target computed by the next-PC logic from nPCOp/imm/zero), including redirects that arrive while a memory request is still outstanding.

## Interface
- RESET_PC, 30'h0000_0C00, word address fetched first after reset (byte address 0x0000_3000).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  30  word address [31:2]; stable while imem_req=1.
- imem_ack  in  1  memory completes the request this cycle; imem_rdata is valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc hold a fetched instruction.
- inst  out  32  fetched instruction.
- inst_pc  out  30  word address of inst.
- inst_ready  in  1  decode accepts inst this cycle.
- redir_valid  in  1  one-cycle redirect pulse.
- redir_target  in  30  next-PC target [31:2], sampled when redir_valid=1.
- halt  in  1  level; stop issuing new fetches.
- pc  out  30  current fetch PC register, which feeds the next-PC logic.

## Operation
- States: IDLE, REQ, HOLD, DRAIN, HALTED. Reset puts the block in IDLE with pc=RESET_PC.
- IDLE: lasts one cycle. Goes to HALTED if halt=1, otherwise to REQ. A redirect seen in IDLE loads pc=redir_target.
- REQ: imem_req=1, imem_addr=pc.
  - imem_ack=1, no redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+1, then go to HOLD.
  - imem_ack=1 with redir_valid=1: discard the data, pc<=redir_target, stay in REQ. The new address is presented on the next cycle.
  - imem_ack=0 with redir_valid=1: pend<=redir_target, then go to DRAIN.
- DRAIN: imem_req stays at 1 with the old address, because an issued request is never withdrawn. A new redirect overwrites pend (latest wins). On imem_ack the data is discarded, pc<=pend (or redir_target if a redirect arrives in the same cycle), then go to REQ.
- HOLD: inst_valid=1, with inst and inst_pc stable.
  - inst_ready=1: the transfer completes. Go to HALTED if halt=1, otherwise to REQ.
  - redir_valid=1 with inst_ready=0: the instruction is killed (inst_valid drops next cycle), pc<=redir_target, go to REQ.
  - redir_valid=1 with inst_ready=1: the transfer still counts and pc<=redir_target.
- HALTED: no requests. A redirect loads pc. When halt falls, go to REQ.
- halt is not sampled in REQ or DRAIN. An outstanding fetch always completes and is delivered first.
- Arithmetic: pc+1 is modulo 2^30, so 30'h3FFF_FFFF wraps to 0. There is no byte offset; bits [1:0] do not exist.
- Only HOLD asserts inst_valid. Only REQ and DRAIN assert imem_req.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- First request: imem_req rises in the 2nd cycle after rst is released.
- Best-case throughput (ack in the same cycle as the request, ready in the same cycle as valid): one instruction per 2 cycles, alternating REQ and HOLD.
- Memory latency of N wait cycles adds N cycles per instruction.
- Redirect-to-request latency:
  - From REQ or HOLD: the request to redir_target is on the bus 1 cycle after redir_valid.
  - From DRAIN: the request appears the cycle after the pending ack.
- rst asserted mid-operation (including during DRAIN with a request outstanding) returns everything to the reset values immediately. Memory must tolerate the dropped request.

## Test plan
- Reset, then ack in the same cycle and ready held at 1: addresses 0xC00, 0xC01, 0xC02 appear on consecutive REQ cycles; inst_pc matches each fetch; inst_valid=1 every other cycle.
- Memory with 3 wait cycles: imem_addr stays stable and imem_req stays at 1 for 4 cycles; the instruction is delivered once, and pc increments once.
- Redirect to 0x100 in the 2nd wait cycle, then another to 0x200 in the 3rd: the old fetch's data is discarded, the next request goes to 0x200, and inst_valid never rises for the old fetch.
- Redirect to 0x40 in HOLD with ready=0: inst_valid drops, the next request goes to 0x40. Repeat with ready=1: the transfer occurs and the next request still goes to 0x40.
- halt=1 during a pending fetch: that instruction is delivered, then there are no requests. A redirect to 0x80 while halted, followed by dropping halt: the next request goes to 0x80.
- Jump to 0x3FFF_FFFF: the next sequential fetch is at 0x0000_0000. Asserting rst during DRAIN gives imem_req=0 in the same cycle with every output at its reset value.

Source files
------------

// File: rtl/pc_seq.sv
// Instruction-fetch sequencer: owns the word-addressed PC, runs one imem req/ack
// transaction at a time and hands fetched instructions to decode over valid/ready.
module pc_seq #(
    parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redir_valid,
    input  logic [29:0] redir_target,
    input  logic        halt,
    output logic [29:0] pc
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        HALTED
    } state_t;

    state_t      state, state_nxt;
    logic [29:0] pc_q, pc_nxt;
    logic [29:0] pend_q, pend_nxt;
    logic [31:0] inst_q;
    logic [29:0] inst_pc_q;
    logic        capture;

    // NOTE: every variable gets a default before the case; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        pend_nxt  = pend_q;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (redir_valid) pc_nxt = redir_target;
                state_nxt = halt ? HALTED : REQ;
            end
            REQ: begin
                if (imem_ack && redir_valid) begin
                    pc_nxt = redir_target;
                end else if (imem_ack) begin
                    capture   = 1'b1;
                    pc_nxt    = pc_q + 30'd1;
                    state_nxt = HOLD;
                end else if (redir_valid) begin
                    pend_nxt  = redir_target;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The issued request stays on the bus; its data is thrown away.
                if (imem_ack) begin
                    pc_nxt    = redir_valid ? redir_target : pend_q;
                    state_nxt = REQ;
                end else if (redir_valid) begin
                    pend_nxt = redir_target;
                end
            end
            HOLD: begin
                if (redir_valid) pc_nxt = redir_target;
                if (inst_ready)       state_nxt = halt ? HALTED : REQ;
                else if (redir_valid) state_nxt = REQ;
            end
            HALTED: begin
                if (redir_valid) pc_nxt = redir_target;
                if (!halt) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            // NOTE: pend is always written before it is read, but resetting it
            // keeps the whole datapath free of X after reset at negligible cost.
            pend_q    <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 30'd0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            pend_q <= pend_nxt;
            if (capture) begin
                inst_q    <= imem_rdata;
                inst_pc_q <= pc_q;
            end
        end
    end

    // Address is the PC itself: DRAIN leaves pc untouched until the ack.
    assign imem_req   = (state == REQ) || (state == DRAIN);
    assign imem_addr  = pc_q;
    assign inst_valid = (state == HOLD);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: steps the fetch sequencer through streaming, wait
// states, redirects, halt, PC wrap and mid-transaction reset.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;
    logic        redir_valid;
    logic [29:0] redir_target;
    logic        halt;
    logic [29:0] pc;

    int total = 0;
    int bad   = 0;

    pc_seq dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt         (halt),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req"},   {31'd0, imem_req},   32'd0);
        check({tag, ".addr"},  {2'd0, imem_addr},   32'h0000_0C00);
        check({tag, ".pc"},    {2'd0, pc},          32'h0000_0C00);
        check({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, ".inst"},  inst,                32'd0);
        check({tag, ".ipc"},   {2'd0, inst_pc},     32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        redir_valid = 1'b0; redir_target = 30'd0; halt = 1'b0;
        tick(); tick();
        check_reset_values("reset");

        // Release: one IDLE cycle, then the first request.
        rst = 1'b0;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req",  {31'd0, imem_req}, 32'd1);
        check("first_addr", {2'd0, imem_addr}, 32'h0000_0C00);

        // Zero-wait streaming with ready held high.
        imem_ack = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s_req",   {31'd0, imem_req},   32'd1);
            check("s_addr",  {2'd0, imem_addr},   32'h0000_0C00 + i);
            check("s_nval",  {31'd0, inst_valid}, 32'd0);
            imem_rdata = 32'hA000_0000 + i;
            tick();
            check("s_valid", {31'd0, inst_valid}, 32'd1);
            check("s_inst",  inst,                32'hA000_0000 + i);
            check("s_ipc",   {2'd0, inst_pc},     32'h0000_0C00 + i);
            check("s_pc",    {2'd0, pc},          32'h0000_0C01 + i);
            check("s_noreq", {31'd0, imem_req},   32'd0);
            tick();
        end

        // Three wait cycles at 0xC03.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w_req",  {31'd0, imem_req}, 32'd1);
            check("w_addr", {2'd0, imem_addr}, 32'h0000_0C03);
            check("w_pc",   {2'd0, pc},        32'h0000_0C03);
            tick();
        end
        check("w_req4",  {31'd0, imem_req}, 32'd1);
        check("w_addr4", {2'd0, imem_addr}, 32'h0000_0C03);
        imem_ack = 1'b1; imem_rdata = 32'hB000_0003;
        tick();
        check("w_valid", {31'd0, inst_valid}, 32'd1);
        check("w_inst",  inst,                32'hB000_0003);
        check("w_ipc",   {2'd0, inst_pc},     32'h0000_0C03);
        check("w_pc1",   {2'd0, pc},          32'h0000_0C04);
        imem_ack = 1'b0;
        tick();
        check("w_once",  {31'd0, inst_valid}, 32'd0);
        check("w_next",  {2'd0, imem_addr},   32'h0000_0C04);

        // Two redirects while the 0xC04 fetch is outstanding; latest wins.
        tick();
        redir_valid = 1'b1; redir_target = 30'h100;
        tick();
        check("d_req",   {31'd0, imem_req}, 32'd1);
        check("d_addr",  {2'd0, imem_addr}, 32'h0000_0C04);
        redir_target = 30'h200;
        tick();
        redir_valid = 1'b0;
        check("d_req2",  {31'd0, imem_req},   32'd1);
        check("d_addr2", {2'd0, imem_addr},   32'h0000_0C04);
        check("d_nval",  {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("d_nval2", {31'd0, inst_valid}, 32'd0);
        check("d_req3",  {31'd0, imem_req},   32'd1);
        check("d_addr3", {2'd0, imem_addr},   32'h0000_0200);
        imem_rdata = 32'hC000_0200;
        tick();
        check("d_valid", {31'd0, inst_valid}, 32'd1);
        check("d_inst",  inst,                32'hC000_0200);
        check("d_ipc",   {2'd0, inst_pc},     32'h0000_0200);

        // HOLD with ready low, then a redirect kills the instruction.
        imem_ack = 1'b0; inst_ready = 1'b0;
        tick();
        check("h_stall", {31'd0, inst_valid}, 32'd1);
        check("h_inst",  inst,                32'hC000_0200);
        redir_valid = 1'b1; redir_target = 30'h40;
        tick();
        redir_valid = 1'b0;
        check("h_kill",  {31'd0, inst_valid}, 32'd0);
        check("h_req",   {31'd0, imem_req},   32'd1);
        check("h_addr",  {2'd0, imem_addr},   32'h0000_0040);
        imem_ack = 1'b1; imem_rdata = 32'hD000_0040;
        tick();
        check("h_valid", {31'd0, inst_valid}, 32'd1);
        check("h_pc",    {2'd0, pc},          32'h0000_0041);
        // Same redirect with ready high: transfer completes, target still taken.
        imem_ack = 1'b0; inst_ready = 1'b1; redir_valid = 1'b1; redir_target = 30'h40;
        tick();
        redir_valid = 1'b0;
        check("r_req",   {31'd0, imem_req},   32'd1);
        check("r_addr",  {2'd0, imem_addr},   32'h0000_0040);
        check("r_nval",  {31'd0, inst_valid}, 32'd0);

        // halt while a fetch is pending: it is delivered, then requests stop.
        halt = 1'b1;
        tick();
        check("t_req",   {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hE000_0040;
        tick();
        imem_ack = 1'b0;
        check("t_valid", {31'd0, inst_valid}, 32'd1);
        check("t_inst",  inst,                32'hE000_0040);
        tick();
        check("t_noreq", {31'd0, imem_req},   32'd0);
        check("t_nval",  {31'd0, inst_valid}, 32'd0);
        tick();
        check("t_noreq2", {31'd0, imem_req}, 32'd0);
        redir_valid = 1'b1; redir_target = 30'h80;
        tick();
        redir_valid = 1'b0;
        check("t_pc",    {2'd0, pc},        32'h0000_0080);
        check("t_noreq3", {31'd0, imem_req}, 32'd0);
        halt = 1'b0;
        tick();
        check("t_req2",  {31'd0, imem_req}, 32'd1);
        check("t_addr",  {2'd0, imem_addr}, 32'h0000_0080);

        // Jump to the top word address; the sequential fetch wraps to 0.
        imem_ack = 1'b1; redir_valid = 1'b1; redir_target = 30'h3FFF_FFFF;
        tick();
        redir_valid = 1'b0;
        check("j_addr",  {2'd0, imem_addr},   32'h3FFF_FFFF);
        check("j_nval",  {31'd0, inst_valid}, 32'd0);
        imem_rdata = 32'hF000_000F;
        tick();
        imem_ack = 1'b0;
        check("j_ipc",   {2'd0, inst_pc},     32'h3FFF_FFFF);
        check("j_pc",    {2'd0, pc},          32'd0);
        tick();
        check("j_req",   {31'd0, imem_req},   32'd1);
        check("j_wrap",  {2'd0, imem_addr},   32'd0);

        // Reset in the middle of DRAIN acts immediately.
        redir_valid = 1'b1; redir_target = 30'h123;
        tick();
        redir_valid = 1'b0;
        check("x_drain", {31'd0, imem_req}, 32'd1);
        check("x_addr",  {2'd0, imem_addr}, 32'd0);
        #1 rst = 1'b1;
        #1 check_reset_values("x_rst");
        tick();
        rst = 1'b0;
        tick();
        check("x_req",   {31'd0, imem_req}, 32'd1);
        check("x_raddr", {2'd0, imem_addr}, 32'h0000_0C00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
